cond_flags_unit: RTL and testbench
==================================

Name: cond_flags_unit

Overview:
- Producer side of the 4-bit condition-flags bus {N, Z, C, V} that the conditional logic unit's condition checker consumes.
- Computes NZCV from the ALU operation of the current instruction and holds them in the architectural flags register.
- Commits new flags only when the instruction sets flags and its condition passed.
- Provides a one-entry shadow (save/restore/swap) for exception entry and return.
- Sits between the ALU and the condition checker in the single-cycle datapath.

Parameters:
- WIDTH, 32, datapath width of the ALU operands and result.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous reset, active low
- src_a  input  WIDTH  ALU operand A
- src_b  input  WIDTH  ALU operand B
- alu_ctrl  input  2  00 ADD, 01 SUB (A-B), 10 AND, 11 ORR
- alu_result  input  WIDTH  ALU result of the current instruction
- flag_set  input  1  instruction S bit; request to update flags
- cond_ex  input  1  condition passed, driven by the condition checker from the current flags
- save  input  1  copy current flags into the shadow register
- restore  input  1  load flags from the shadow register
- flags  output  4  registered {N, Z, C, V}, bit 3 = N
- shadow_flags  output  4  registered shadow copy, same bit order
- flags_wr  output  1  registered; 1 for the cycle after any flags register update

Behaviour:
- Reset: one clk and rst_n is synchronous, active low. While rst_n=0 at a rising edge:
  - flags=4'b0000, shadow_flags=4'b0000, flags_wr=0.
  - All other inputs are ignored that cycle.
  - Reset asserted in the middle of an update cycle wins: no update occurs.
- Next-flag computation (combinational, internal):
  - N_next = alu_result[WIDTH-1]; Z_next = (alu_result == 0).
  - ADD: {carry, sum} = {1'b0,A} + {1'b0,B}, WIDTH+1 bits. C_next = carry. V_next = (A[msb]==B[msb]) & (sum[msb]!=A[msb]).
  - SUB: computed as A + ~B + 1, WIDTH+1 bits. C_next = carry-out, where 1 = no borrow (ARM convention). V_next = (A[msb]!=B[msb]) & (diff[msb]!=A[msb]).
  - AND/ORR: N and Z are updated; C and V keep their register values.
  - N/Z always come from alu_result; the internal sum is used only for C/V.
- Update condition: upd = flag_set & cond_ex. No update when cond_ex=0, even with flag_set=1.
- Register update priority per rising edge with rst_n=1:
  1. restore & save → swap: flags <= shadow_flags; shadow_flags <= flags (values before the edge).
  2. restore only → flags <= shadow_flags. A simultaneous upd is discarded.
  3. save only → shadow_flags <= flags (pre-update value). flags still updates if upd=1.
  4. upd only → flags <= {N_next, Z_next, C_next, V_next}, with the AND/ORR masking above.
  5. otherwise → hold.
- flags_wr <= 1 when flags is written by case 1, 2 or 4, including writes of an identical value; else 0.
- Latency: new flags are visible on the cycle after the edge. Combinational feedback from flags to cond_ex is legal because flags is registered only.
- No X propagation: every alu_ctrl encoding is defined, and there is no default-x branch.

Test Plan:
- Reset: rst_n=0 for 2 cycles with flag_set=1, cond_ex=1, save=1 → flags=0000, shadow_flags=0000, flags_wr=0. Release → still 0000.
- ADD overflow: A=0x7FFFFFFF, B=0x00000001, result=0x80000000, flag_set=1, cond_ex=1 → next cycle flags=1001, flags_wr=1. Then A=0xFFFFFFFF, B=1, result=0 → flags=0110.
- SUB: 5-5, result=0 → flags=0110. Then 3-5, result=0xFFFFFFFE → flags=1000 (borrow, C=0).
- Condition/S gating:
  - From flags=0110, SUB 3-5 with cond_ex=0 → flags stays 0110, flags_wr=0.
  - With flag_set=0, cond_ex=1 → same result.
- Logic op: from flags=0110, AND with result=0x80000000 → flags=1010 (C held 1, V held 0).
- Save/restore:
  - flags=1001, save=1 with an upd producing 0110 → shadow_flags=1001, flags=0110.
  - Then restore=1 with an upd → flags=1001, upd discarded.
  - Then save=restore=1 with shadow=1001, flags=1001 → swap, both 1001, flags_wr=1.

Source files
------------

// File: rtl/cond_flags_unit.sv
// Condition-flags producer: computes NZCV from the current ALU operation and holds the
// architectural flags register plus a one-entry shadow used on exception entry and return.
module cond_flags_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic [1:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             flag_set,
    input  logic             cond_ex,
    input  logic             save,
    input  logic             restore,
    output logic [3:0]       flags,
    output logic [3:0]       shadow_flags,
    output logic             flags_wr
);

    localparam logic [1:0] AluAdd = 2'b00;
    localparam logic [1:0] AluSub = 2'b01;
    localparam logic [1:0] AluAnd = 2'b10;
    localparam logic [1:0] AluOrr = 2'b11;

    logic [3:0]     flags_q, flags_d;
    logic [3:0]     shadow_q, shadow_d;
    logic           flags_wr_q, flags_wr_d;

    logic [WIDTH:0] sum_add;
    logic [WIDTH:0] sum_sub;
    logic           n_next, z_next, c_next, v_next;
    logic           upd;
    logic           msb_a, msb_b;

    assign msb_a = src_a[WIDTH-1];
    assign msb_b = src_b[WIDTH-1];

    // Internal adder only feeds C/V; N/Z always follow the ALU's own result.
    assign sum_add = {1'b0, src_a} + {1'b0, src_b};
    assign sum_sub = {1'b0, src_a} + {1'b0, ~src_b} + {{WIDTH{1'b0}}, 1'b1};

    assign upd = flag_set & cond_ex;

    always_comb begin
        n_next = alu_result[WIDTH-1];
        z_next = (alu_result == '0);
        c_next = flags_q[1];
        v_next = flags_q[0];
        unique case (alu_ctrl)
            AluAdd: begin
                c_next = sum_add[WIDTH];
                v_next = (msb_a == msb_b) & (sum_add[WIDTH-1] != msb_a);
            end
            AluSub: begin
                // Carry-out of A + ~B + 1: 1 means no borrow.
                c_next = sum_sub[WIDTH];
                v_next = (msb_a != msb_b) & (sum_sub[WIDTH-1] != msb_a);
            end
            AluAnd, AluOrr: begin
                c_next = flags_q[1];
                v_next = flags_q[0];
            end
        endcase
    end

    always_comb begin
        flags_d    = flags_q;
        shadow_d   = shadow_q;
        flags_wr_d = 1'b0;
        if (restore && save) begin
            flags_d    = shadow_q;
            shadow_d   = flags_q;
            flags_wr_d = 1'b1;
        end else if (restore) begin
            // A pending update is dropped: the restored value takes precedence.
            flags_d    = shadow_q;
            flags_wr_d = 1'b1;
        end else begin
            if (save) begin
                shadow_d = flags_q;
            end
            if (upd) begin
                flags_d    = {n_next, z_next, c_next, v_next};
                flags_wr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flags_q    <= 4'b0000;
            shadow_q   <= 4'b0000;
            flags_wr_q <= 1'b0;
        end else begin
            flags_q    <= flags_d;
            shadow_q   <= shadow_d;
            flags_wr_q <= flags_wr_d;
        end
    end

    assign flags        = flags_q;
    assign shadow_flags = shadow_q;
    assign flags_wr     = flags_wr_q;

endmodule

// File: tb/tb_cond_flags_unit.sv
// Scoreboard bench for cond_flags_unit: directed test-plan sequence followed by random traffic,
// checked against an arithmetic reference model of the flag rules.
module tb_cond_flags_unit;

    localparam int unsigned WIDTH = 32;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] src_a, src_b, alu_result;
    logic [1:0]       alu_ctrl;
    logic             flag_set, cond_ex, save, restore;
    logic [3:0]       flags, shadow_flags;
    logic             flags_wr;

    cond_flags_unit #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .src_a       (src_a),
        .src_b       (src_b),
        .alu_ctrl    (alu_ctrl),
        .alu_result  (alu_result),
        .flag_set    (flag_set),
        .cond_ex     (cond_ex),
        .save        (save),
        .restore     (restore),
        .flags       (flags),
        .shadow_flags(shadow_flags),
        .flags_wr    (flags_wr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] flags;
        logic [3:0] shadow;
        logic       wr;
    } exp_t;

    exp_t       exp_q[$];
    int         n_checks = 0;
    int         n_pass   = 0;
    logic [3:0] m_flags  = 4'b0000;
    logic [3:0] m_shadow = 4'b0000;

    // Reference flag computation using plain integer arithmetic.
    function automatic logic [3:0] model_next(input logic [31:0] a, input logic [31:0] b,
                                              input logic [1:0] op, input logic [31:0] res,
                                              input logic [3:0] cur);
        logic n, z, c, v;
        longint sa, sb, s;
        longint unsigned ua, ub;
        n  = res[31];
        z  = (res == 32'd0);
        c  = cur[1];
        v  = cur[0];
        ua = longint'(a);
        ub = longint'(b);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (op == 2'b00) begin
            c = (ua + ub) > 64'h0000_0000_FFFF_FFFF;
            s = sa + sb;
            v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        end else if (op == 2'b01) begin
            c = (ua >= ub);
            s = sa - sb;
            v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        end
        return {n, z, c, v};
    endfunction

    task automatic drive(input logic rst, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] op, input logic [31:0] res, input logic fs,
                         input logic ce, input logic sv, input logic rs);
        exp_t e;
        logic [3:0] nf;
        @(negedge clk);
        rst_n      = rst;
        src_a      = a;
        src_b      = b;
        alu_ctrl   = op;
        alu_result = res;
        flag_set   = fs;
        cond_ex    = ce;
        save       = sv;
        restore    = rs;
        nf         = model_next(a, b, op, res, m_flags);
        e.wr       = 1'b0;
        if (!rst) begin
            m_flags  = 4'b0000;
            m_shadow = 4'b0000;
        end else if (rs && sv) begin
            {m_flags, m_shadow} = {m_shadow, m_flags};
            e.wr = 1'b1;
        end else if (rs) begin
            m_flags = m_shadow;
            e.wr    = 1'b1;
        end else begin
            if (sv) m_shadow = m_flags;
            if (fs && ce) begin
                m_flags = nf;
                e.wr    = 1'b1;
            end
        end
        e.flags  = m_flags;
        e.shadow = m_shadow;
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, req, $time);
    endtask

    // Monitor: one expected entry per driven cycle, compared after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("flags", flags, e.flags);
                check("shadow_flags", shadow_flags, e.shadow);
                check("flags_wr", {3'b000, flags_wr}, {3'b000, e.wr});
            end
        end
    end

    function automatic logic [31:0] pick_operand();
        logic [31:0] edges [6];
        edges[0] = 32'h0000_0000; edges[1] = 32'h0000_0001; edges[2] = 32'h7FFF_FFFF;
        edges[3] = 32'h8000_0000; edges[4] = 32'hFFFF_FFFF; edges[5] = 32'h8000_0001;
        if ($urandom_range(0, 3) == 0) return edges[$urandom_range(0, 5)];
        return $urandom();
    endfunction

    function automatic logic [31:0] alu_of(input logic [31:0] a, input logic [31:0] b,
                                           input logic [1:0] op);
        case (op)
            2'b00:   return a + b;
            2'b01:   return a - b;
            2'b10:   return a & b;
            default: return a | b;
        endcase
    endfunction

    initial begin
        int waited;
        rst_n = 1'b0; src_a = '0; src_b = '0; alu_ctrl = 2'b00; alu_result = '0;
        flag_set = 1'b0; cond_ex = 1'b0; save = 1'b0; restore = 1'b0;

        // Reset with update/save requests present, then release.
        drive(0, 32'h7FFF_FFFF, 32'h1, 2'b00, 32'h8000_0000, 1, 1, 1, 0);
        drive(0, 32'h7FFF_FFFF, 32'h1, 2'b00, 32'h8000_0000, 1, 1, 1, 0);
        drive(1, 32'h0, 32'h0, 2'b00, 32'h0, 0, 0, 0, 0);
        // ADD overflow -> 1001, then carry-out to zero -> 0110.
        drive(1, 32'h7FFF_FFFF, 32'h1, 2'b00, 32'h8000_0000, 1, 1, 0, 0);
        drive(1, 32'hFFFF_FFFF, 32'h1, 2'b00, 32'h0, 1, 1, 0, 0);
        // SUB 5-5 -> 0110, 3-5 -> 1000.
        drive(1, 32'd5, 32'd5, 2'b01, 32'h0, 1, 1, 0, 0);
        drive(1, 32'd3, 32'd5, 2'b01, 32'hFFFF_FFFE, 1, 1, 0, 0);
        // Back to 0110, then gated updates hold it.
        drive(1, 32'd5, 32'd5, 2'b01, 32'h0, 1, 1, 0, 0);
        drive(1, 32'd3, 32'd5, 2'b01, 32'hFFFF_FFFE, 1, 0, 0, 0);
        drive(1, 32'd3, 32'd5, 2'b01, 32'hFFFF_FFFE, 0, 1, 0, 0);
        // AND from 0110 -> 1010.
        drive(1, 32'h8000_0000, 32'hFFFF_FFFF, 2'b10, 32'h8000_0000, 1, 1, 0, 0);
        // Reach 1001, save while updating to 0110, restore over an update, then swap.
        drive(1, 32'h7FFF_FFFF, 32'h1, 2'b00, 32'h8000_0000, 1, 1, 0, 0);
        drive(1, 32'd5, 32'd5, 2'b01, 32'h0, 1, 1, 1, 0);
        drive(1, 32'd3, 32'd5, 2'b01, 32'hFFFF_FFFE, 1, 1, 0, 1);
        drive(1, 32'd0, 32'd0, 2'b00, 32'h0, 0, 0, 1, 1);

        for (int i = 0; i < 600; i++) begin
            logic [31:0] a, b, r;
            logic [1:0]  op;
            a  = pick_operand();
            b  = pick_operand();
            op = 2'($urandom_range(0, 3));
            r  = ($urandom_range(0, 3) == 0) ? $urandom() : alu_of(a, b, op);
            drive(($urandom_range(0, 40) != 0), a, b, op, r,
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0));
        end

        drive(1, 32'd0, 32'd0, 2'b00, 32'h0, 0, 0, 0, 0);
        waited = 0;
        while (exp_q.size() > 0 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (exp_q.size() > 0) begin
            n_checks++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
